// File: rtl/uart_pkg.sv
// Shared UART/RS constants and types: default bit timing, frame length,
// transmitter state encoding and the RS block geometry used by the decoder.
// No ports; imported by the transmitter, its interface and its FIFO users.
package uart_pkg;

  localparam int DEF_CLKS_PER_BIT = 864;  // 100 MHz clock, ~115.7 kbaud
  localparam int FRAME_BITS       = 11;   // start + 8 data + parity + stop

  // RS(204,188) block geometry, shared with the RS decoder and its FSM.
  localparam int RS_N = 204;
  localparam int RS_K = 188;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte handshake between a byte source (e.g. the RS decoder) and the UART tx.
// Signals: tx_data (byte), tx_valid (source has a byte), tx_ready (sink accepts).
// A byte transfers on a rising edge where tx_valid && tx_ready.
interface uart_transmitter_if;
  import uart_pkg::*;

  byte_t tx_data;
  logic  tx_valid;
  logic  tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; head visible combinationally.
// Ports: push_i/push_dat_i write, pop_i/pop_dat_o read, full_o, empty_o, count_o.
// Pushes while full and pops while empty are ignored; DEPTH must be a power of 2.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       pop_dat_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign pop_dat_o = mem_q[rd_ptr_q];
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;

  // Storage is not reset: a cleared count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: buffers bytes in a FIFO and sends start/8 data LSB-first/parity/stop.
// Ports: clk, reset (async active-low), tx_if (slave handshake), Tx_D serial out,
// busy (frame in flight or bytes queued), fifo_count; first start bit 1 cycle after accept.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  uart_transmitter_if.slave           tx_if,
  output logic                        Tx_D,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int              BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic            PAR_INV   = (PARITY_ODD != 0);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_START  = START;
  localparam logic [2:0] ST_DATA   = DATA;
  localparam logic [2:0] ST_PARITY = PARITY;
  localparam logic [2:0] ST_STOP   = STOP;

  logic [2:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  byte_t         shift_q, shift_d;
  logic          parity_q, parity_d;
  logic          tx_q, tx_d;

  logic          fifo_pop;
  logic          fifo_empty;
  logic          fifo_full;
  byte_t         fifo_dat;
  logic          baud_done;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .push_i     (tx_if.tx_valid),
    .push_dat_i (tx_if.tx_data),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  assign tx_if.tx_ready = !fifo_full;
  assign baud_done      = (baud_q == BAUD_LAST);
  assign busy           = (state_q != ST_IDLE) || !fifo_empty;
  assign Tx_D           = tx_q;

  // tx_d is the line value for the next bit period, so Tx_D comes straight
  // from a flop and changes exactly on bit boundaries.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tx_d      = tx_q;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dat;
          parity_d = (^fifo_dat) ^ PAR_INV;
          state_d  = ST_START;
          tx_d     = 1'b0;
        end
      end
      ST_START: begin
        if (baud_done) begin
          state_d   = ST_DATA;
          baud_d    = '0;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_PARITY;
            tx_d    = parity_q;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[bit_idx_q + 3'd1];
          end
        end
      end
      ST_PARITY: begin
        if (baud_done) begin
          state_d = ST_STOP;
          baud_d  = '0;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          // Reload straight from the stop bit so queued frames abut with no idle gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dat;
            parity_d = (^fifo_dat) ^ PAR_INV;
            state_d  = ST_START;
            tx_d     = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
    end
  end

endmodule
